alu_seq: RTL and testbench

- Parametrised, registered successor to the combinational CPU ALU.
- Adds generic data width, correct 6502-style borrow and overflow semantics, and left rotate.
- Adds BCD decimal add/subtract, processed one digit per cycle.
- Sits between the decoder/sequencer and the register file; uses a valid/ready handshake on both sides and a registered result with flags.

---
 rtl/alu_seq.sv | 210 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
//
// Binary operations are computed on the accept edge and presented one cycle later.
// Decimal (BCD) ADD/SUB walks the operands one nibble per clock, least significant
// digit first, and presents the result WIDTH/4+1 cycles after accept.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   request handshake; in_ready is high only in IDLE
//   op_a, op_b            operands
//   mode                  0=ADD 1=SUB 2=AND 3=OR 4=EOR 5=SR 6=SL 7=CMP, others=PASS A
//   carry_in              carry / not-borrow / rotate-in bit
//   decimal               BCD mode for ADD/SUB (ignored when DECIMAL_EN=0)
//   out_valid / out_ready result handshake; outputs are held while out_ready=0
//   result                registered result
//   carry_out, overflow, zero, sign   registered C, V, Z, N flags
module alu_seq #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DECIMAL_EN = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       mode,
    input  logic             carry_in,
    input  logic             decimal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             sign
);

    localparam int unsigned Digits   = (WIDTH >= 4) ? WIDTH / 4 : 1;
    localparam int unsigned CntW     = (Digits > 1) ? $clog2(Digits) : 1;
    localparam int unsigned TopShift = (WIDTH >= 4) ? WIDTH - 4 : 0;
    localparam logic [CntW-1:0] LastDigit = CntW'(Digits - 1);

    localparam logic [4:0] ModeAdd = 5'd0;
    localparam logic [4:0] ModeSub = 5'd1;
    localparam logic [4:0] ModeAnd = 5'd2;
    localparam logic [4:0] ModeOr  = 5'd3;
    localparam logic [4:0] ModeEor = 5'd4;
    localparam logic [4:0] ModeSr  = 5'd5;
    localparam logic [4:0] ModeSl  = 5'd6;
    localparam logic [4:0] ModeCmp = 5'd7;

    if (DECIMAL_EN != 0 && (WIDTH % 4) != 0) begin : g_width_check
        $error("alu_seq: WIDTH must be a multiple of 4 when DECIMAL_EN=1");
    end
    if (WIDTH < 4) begin : g_min_width_check
        $error("alu_seq: WIDTH must be at least 4");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q, b_q, acc_q;
    logic [CntW-1:0]   cnt_q;
    logic              dc_q;      // digit carry (ADD) or digit borrow (SUB)
    logic              sub_q;
    logic              dec_v_q;   // V is the binary overflow of the same operands
    logic [WIDTH-1:0]  result_q;
    logic              c_q, v_q, z_q, n_q;

    // Binary datapath, evaluated from the live inputs on the accept edge.
    logic [WIDTH-1:0] bop;
    logic             cin_eff;
    logic [WIDTH:0]   sum;
    logic             arith_v;
    logic [WIDTH-1:0] bin_r, flag_val;
    logic             bin_c, bin_v, bin_z, bin_n;
    logic             dec_sel;

    always_comb begin
        bop      = (mode == ModeSub || mode == ModeCmp) ? ~op_b : op_b;
        cin_eff  = (mode == ModeCmp) ? 1'b1 : carry_in;
        sum      = {1'b0, op_a} + {1'b0, bop} + {{WIDTH{1'b0}}, cin_eff};
        arith_v  = (op_a[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        bin_r    = op_a;
        bin_c    = carry_in;
        bin_v    = 1'b0;
        case (mode)
            ModeAdd, ModeSub: begin
                bin_r = sum[WIDTH-1:0];
                bin_c = sum[WIDTH];
                bin_v = arith_v;
            end
            ModeAnd: bin_r = op_a & op_b;
            ModeOr:  bin_r = op_a | op_b;
            ModeEor: bin_r = op_a ^ op_b;
            ModeSr: begin
                bin_r = {carry_in, op_a[WIDTH-1:1]};
                bin_c = op_a[0];
            end
            ModeSl: begin
                bin_r = {op_a[WIDTH-2:0], carry_in};
                bin_c = op_a[WIDTH-1];
            end
            ModeCmp: bin_c = sum[WIDTH];
            default: bin_r = op_a;
        endcase
        // CMP reports A on result but flags the difference.
        flag_val = (mode == ModeCmp) ? sum[WIDTH-1:0] : bin_r;
        bin_z    = (flag_val == '0);
        bin_n    = flag_val[WIDTH-1];
        dec_sel  = (DECIMAL_EN != 0) && decimal && (mode == ModeAdd || mode == ModeSub);
    end

    // One BCD digit per cycle from the low nibbles of the shifting operand registers.
    logic [4:0]       dsum, ddif;
    logic [3:0]       digit;
    logic             dc_next;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        dsum = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, dc_q};
        ddif = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0, dc_q};
        if (sub_q) begin
            // ddif[4] is the sign of the 5-bit difference; correction wraps mod 16.
            digit   = ddif[4] ? (ddif[3:0] - 4'd6) : ddif[3:0];
            dc_next = ddif[4];
        end else if (dsum > 5'd9) begin
            digit   = dsum[3:0] + 4'd6;
            dc_next = 1'b1;
        end else begin
            digit   = dsum[3:0];
            dc_next = 1'b0;
        end
        acc_next = (acc_q >> 4) | (WIDTH'(digit) << TopShift);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            dc_q     <= 1'b0;
            sub_q    <= 1'b0;
            dec_v_q  <= 1'b0;
            result_q <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (dec_sel) begin
                            a_q     <= op_a;
                            b_q     <= op_b;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            sub_q   <= (mode == ModeSub);
                            // SUB starts with borrow = !carry_in.
                            dc_q    <= (mode == ModeSub) ? ~carry_in : carry_in;
                            dec_v_q <= bin_v;
                            state_q <= StCalc;
                        end else begin
                            result_q <= bin_r;
                            c_q      <= bin_c;
                            v_q      <= bin_v;
                            z_q      <= bin_z;
                            n_q      <= bin_n;
                            state_q  <= StDone;
                        end
                    end
                end
                StCalc: begin
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    acc_q <= acc_next;
                    dc_q  <= dc_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastDigit) begin
                        result_q <= acc_next;
                        c_q      <= sub_q ? ~dc_next : dc_next;
                        v_q      <= dec_v_q;
                        z_q      <= (acc_next == '0);
                        n_q      <= acc_next[WIDTH-1];
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign carry_out = c_q;
    assign overflow  = v_q;
    assign zero      = z_q;
    assign sign      = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against a behavioural model.
// Instances: 0 = WIDTH 8 decimal, 1 = WIDTH 16 decimal, 2 = WIDTH 8 binary-only.
module tb_alu_seq;

    logic clk;
    logic reset_n;

    logic [15:0] a_s [3];
    logic [15:0] b_s [3];
    logic [4:0]  m_s [3];
    logic [2:0]  iv_s, cin_s, dec_s, ordy_s;
    logic [2:0]  ir_w, ov_w, c_w, v_w, z_w, n_w;
    logic [7:0]  r0, r2;
    logic [15:0] r1;
    logic [15:0] res_w [3];

    assign res_w[0] = {8'h00, r0};
    assign res_w[1] = r1;
    assign res_w[2] = {8'h00, r2};

    int n_checks = 0;
    int n_err    = 0;

    alu_seq #(.WIDTH(8), .DECIMAL_EN(1)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv_s[0]), .in_ready(ir_w[0]),
        .op_a(a_s[0][7:0]), .op_b(b_s[0][7:0]), .mode(m_s[0]), .carry_in(cin_s[0]),
        .decimal(dec_s[0]), .out_valid(ov_w[0]), .out_ready(ordy_s[0]), .result(r0),
        .carry_out(c_w[0]), .overflow(v_w[0]), .zero(z_w[0]), .sign(n_w[0])
    );

    alu_seq #(.WIDTH(16), .DECIMAL_EN(1)) dut16 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv_s[1]), .in_ready(ir_w[1]),
        .op_a(a_s[1]), .op_b(b_s[1]), .mode(m_s[1]), .carry_in(cin_s[1]),
        .decimal(dec_s[1]), .out_valid(ov_w[1]), .out_ready(ordy_s[1]), .result(r1),
        .carry_out(c_w[1]), .overflow(v_w[1]), .zero(z_w[1]), .sign(n_w[1])
    );

    alu_seq #(.WIDTH(8), .DECIMAL_EN(0)) dut_nd (
        .clk(clk), .reset_n(reset_n), .in_valid(iv_s[2]), .in_ready(ir_w[2]),
        .op_a(a_s[2][7:0]), .op_b(b_s[2][7:0]), .mode(m_s[2]), .carry_in(cin_s[2]),
        .decimal(dec_s[2]), .out_valid(ov_w[2]), .out_ready(ordy_s[2]), .result(r2),
        .carry_out(c_w[2]), .overflow(v_w[2]), .zero(z_w[2]), .sign(n_w[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: ALU rules evaluated with plain integer arithmetic.
    function automatic void model(input int w, input bit den, input int mode, input int a,
                                  input int b, input bit cin, input bit dec, output int r,
                                  output bit c, output bit v, output bit z, output bit n,
                                  output int lat);
        int mask, msb, bop, s, diff, fv, cy, da, db, t;
        mask = (1 << w) - 1;
        msb  = w - 1;
        r    = a;
        c    = cin;
        v    = 1'b0;
        lat  = 1;
        fv   = a;
        bop  = (mode == 1 || mode == 7) ? (~b & mask) : b;
        s    = a + bop + ((mode == 7) ? 1 : int'(cin));
        diff = s & mask;
        if (den && dec && (mode == 0 || mode == 1)) begin
            v  = (((a >> msb) & 1) == ((bop >> msb) & 1)) &&
                 (((diff >> msb) & 1) != ((a >> msb) & 1));
            cy = (mode == 0) ? int'(cin) : int'(!cin);
            r  = 0;
            for (int i = 0; i < w / 4; i++) begin
                da = (a >> (4 * i)) & 15;
                db = (b >> (4 * i)) & 15;
                if (mode == 0) begin
                    t = da + db + cy;
                    if (t > 9) begin t = t + 6; cy = 1; end else cy = 0;
                end else begin
                    t = da - db - cy;
                    if (t < 0) begin t = t - 6; cy = 1; end else cy = 0;
                end
                r = r | ((t & 15) << (4 * i));
            end
            c   = (mode == 0) ? (cy != 0) : (cy == 0);
            lat = w / 4 + 1;
            fv  = r;
        end else begin
            case (mode)
                0, 1: begin
                    r = diff;
                    c = ((s >> w) & 1) != 0;
                    v = (((a >> msb) & 1) == ((bop >> msb) & 1)) &&
                        (((diff >> msb) & 1) != ((a >> msb) & 1));
                end
                2: r = a & b;
                3: r = a | b;
                4: r = a ^ b;
                5: begin r = (int'(cin) << msb) | (a >> 1); c = (a & 1) != 0; end
                6: begin r = ((a << 1) | int'(cin)) & mask; c = ((a >> msb) & 1) != 0; end
                7: begin r = a; c = ((s >> w) & 1) != 0; end
                default: r = a;
            endcase
            fv = (mode == 7) ? diff : r;
        end
        z = (fv == 0);
        n = ((fv >> msb) & 1) != 0;
    endfunction

    function automatic int width_of(input int k);
        return (k == 1) ? 16 : 8;
    endfunction

    task automatic run_op(input int k, input int mode, input int a, input int b,
                          input bit cin, input bit dec, input int hold);
        int  er, elat, lat, w;
        bit  ec, ev, ez, en, seen;
        logic [15:0] held;
        w = width_of(k);
        model(w, k != 2, mode, a, b, cin, dec, er, ec, ev, ez, en, elat);
        @(negedge clk);
        a_s[k] = 16'(a); b_s[k] = 16'(b); m_s[k] = 5'(mode);
        cin_s[k] = cin; dec_s[k] = dec; iv_s[k] = 1'b1; ordy_s[k] = 1'b0;
        check_eq("in_ready_idle", 32'(ir_w[k]), 32'd1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            iv_s[k] = 1'b0;
            seen = ov_w[k];
        end
        check_eq("latency", 32'(lat), 32'(elat));
        check_eq("in_ready_busy", 32'(ir_w[k]), 32'd0);
        check_eq("result", 32'(res_w[k]), 32'(er));
        check_eq("carry", 32'(c_w[k]), 32'(ec));
        check_eq("overflow", 32'(v_w[k]), 32'(ev));
        check_eq("zero", 32'(z_w[k]), 32'(ez));
        check_eq("sign", 32'(n_w[k]), 32'(en));
        held = res_w[k];
        for (int i = 0; i < hold; i++) begin
            a_s[k] = ~a_s[k]; m_s[k] = 5'(i); iv_s[k] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_valid", 32'(ov_w[k]), 32'd1);
            check_eq("hold_ready", 32'(ir_w[k]), 32'd0);
            check_eq("hold_result", 32'(res_w[k]), 32'(held));
            check_eq("hold_carry", 32'(c_w[k]), 32'(ec));
        end
        iv_s[k]   = 1'b0;
        ordy_s[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy_s[k] = 1'b0;
        check_eq("pop_valid", 32'(ov_w[k]), 32'd0);
        check_eq("pop_ready", 32'(ir_w[k]), 32'd1);
    endtask

    initial begin
        int k, w, mask;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_s[i] = '0; b_s[i] = '0; m_s[i] = '0;
        end
        iv_s = '0; cin_s = '0; dec_s = '0; ordy_s = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_valid", 32'(ov_w[i]), 32'd0);
            check_eq("rst_result", 32'(res_w[i]), 32'd0);
            check_eq("rst_flags", 32'({c_w[i], v_w[i], z_w[i], n_w[i]}), 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_eq("rst_ready", 32'(ir_w[i]), 32'd1);

        // Directed cases.
        run_op(0, 0, 'h50, 'h50, 1'b0, 1'b0, 0);
        run_op(0, 1, 'h00, 'h01, 1'b1, 1'b0, 0);
        run_op(0, 7, 'h40, 'h40, 1'b0, 1'b0, 0);
        run_op(0, 0, 'h58, 'h46, 1'b1, 1'b1, 0);
        run_op(0, 1, 'h12, 'h21, 1'b1, 1'b1, 0);
        run_op(2, 1, 'h12, 'h21, 1'b1, 1'b1, 0);
        run_op(0, 5, 'h01, 'h00, 1'b1, 1'b0, 0);
        run_op(0, 6, 'h80, 'h00, 1'b0, 1'b0, 0);
        run_op(0, 20, 'h3C, 'h11, 1'b1, 1'b1, 0);
        run_op(0, 0, 'h27, 'h35, 1'b0, 1'b1, 5);
        run_op(1, 0, 'h9999, 'h0001, 1'b0, 1'b1, 0);
        run_op(1, 1, 'h1000, 'h0001, 1'b1, 1'b1, 1);

        // Reset in the middle of a decimal operation.
        run_op(0, 0, 'h50, 'h50, 1'b0, 1'b0, 0);
        @(negedge clk);
        a_s[0] = 16'h0058; b_s[0] = 16'h0046; m_s[0] = 5'd0;
        cin_s[0] = 1'b0; dec_s[0] = 1'b1; iv_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv_s[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(ov_w[0]), 32'd0);
        check_eq("midrst_result", 32'(res_w[0]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_ready", 32'(ir_w[0]), 32'd1);
        run_op(0, 0, 'h58, 'h46, 1'b1, 1'b1, 0);

        // Randomized operations across all three builds.
        for (int it = 0; it < 60; it++) begin
            k    = int'($urandom_range(0, 2));
            w    = width_of(k);
            mask = (1 << w) - 1;
            run_op(k, int'($urandom_range(0, 9)), int'($urandom) & mask,
                   int'($urandom) & mask, 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
